// File: rtl/mem_stage_hs_pkg.sv
// Shared types for the handshake MEM stage: load encodings, exception code and the
// EX->MEM / MEM->WB bus layouts (req_sent sits at bit 154 of the EX bus).
package mem_stage_hs_pkg;

  typedef enum logic [2:0] {
    LT_NONE = 3'd0,
    LT_LB   = 3'd1,
    LT_LBU  = 3'd2,
    LT_LH   = 3'd3,
    LT_LHU  = 3'd4,
    LT_LW   = 3'd5,
    LT_LWL  = 3'd6,
    LT_LWR  = 3'd7
  } load_type_t;

  localparam logic [3:0] ADEL_MEM = 4'h4;

  typedef struct packed {
    logic        req_sent;
    load_type_t  load_type;
    logic        res_from_mem;
    logic [31:0] rt_value;
    logic [31:0] vaddr;
    logic        bd;
    logic        eret;
    logic [3:0]  exc_type;
    logic [7:0]  rd_sel;
    logic        res_from_cp0;
    logic        mtc0_we;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic [31:0] vaddr;
    logic        bd;
    logic        eret;
    logic [3:0]  exc_type;
    logic [7:0]  rd_sel;
    logic        res_from_cp0;
    logic        mtc0_we;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

  localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
  localparam int MS_TO_WS_BUS_WD = $bits(ms_to_ws_t);

  // EX never issues a request for these, so MEM must not wait on them.
  function automatic logic misaligned(input load_type_t t, input logic [1:0] a);
    case (t)
      LT_LW:         misaligned = (a != 2'b00);
      LT_LH, LT_LHU: misaligned = a[0];
      default:       misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_hs_load_align.sv
// Combinational load alignment: byte/half extension and LWL/LWR merge with rt.
module load_align
  import mem_stage_hs_pkg::*;
#(
  parameter bit LWLR_EN = 1'b1
) (
  input  load_type_t  load_type,
  input  logic [1:0]  addr_low,
  input  logic [31:0] rdata,
  input  logic [31:0] rt,
  output logic [31:0] result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[7:0];
    case (addr_low)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
    endcase
    sel_half = addr_low[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (load_type)
      LT_LB:  result = {{24{sel_byte[7]}}, sel_byte};
      LT_LBU: result = {24'h0, sel_byte};
      LT_LH:  result = {{16{sel_half[15]}}, sel_half};
      LT_LHU: result = {16'h0, sel_half};
      LT_LWL:
        if (LWLR_EN) begin
          case (addr_low)
            2'd0: result = {rdata[7:0],  rt[23:0]};
            2'd1: result = {rdata[15:0], rt[15:0]};
            2'd2: result = {rdata[23:0], rt[7:0]};
            2'd3: result = rdata;
          endcase
        end
      LT_LWR:
        if (LWLR_EN) begin
          case (addr_low)
            2'd0: result = rdata;
            2'd1: result = {rt[31:24], rdata[31:8]};
            2'd2: result = {rt[31:16], rdata[31:16]};
            2'd3: result = {rt[31:8],  rdata[31:24]};
          endcase
        end
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM stage with valid/ok load handshake: holds early data for WB and counts
// responses that belong to flushed loads so they can be swallowed.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int DW        = 32,
  parameter int MAX_OUTST = 2,
  parameter bit LWLR_EN   = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_ok,
  input  logic [DW-1:0]              data_rdata,
  input  logic                       es_req_pending,
  input  logic                       ws_ex,
  input  logic                       eret_flush,
  output logic                       out_ms_valid,
  output logic [3:0]                 ms_exc_type,
  output logic                       ms_eret
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  es_to_ms_t       entry;
  ms_to_ws_t       out_bus;
  logic            ms_valid;
  logic            buf_valid;
  logic [DW-1:0]   buf_data;
  logic [CNT_W-1:0] cancel_cnt;
  logic [CNT_W:0]  cnt_next;

  logic flush, cnt_zero, wait_data, owned_ok, discard_ok;
  logic ms_ready_go, buf_write;
  logic [DW-1:0] load_data;
  logic [31:0]   aligned, final_result;

  assign flush       = ws_ex | eret_flush;
  assign cnt_zero    = (cancel_cnt == '0);
  assign wait_data   = ms_valid & entry.req_sent & entry.res_from_mem & ~buf_valid;
  assign owned_ok    = data_ok & cnt_zero;
  assign discard_ok  = data_ok & ~cnt_zero;
  assign ms_ready_go = ~wait_data | owned_ok;
  assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  assign buf_write   = wait_data & owned_ok & ~ws_allowin & ~flush;

  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) entry <= es_to_ms_t'(es_to_ms_bus);
  end

  always_ff @(posedge clk) begin
    if (reset)           ms_valid <= 1'b0;
    else if (flush)      ms_valid <= 1'b0;
    else if (ms_allowin) ms_valid <= es_to_ms_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)                                   buf_valid <= 1'b0;
    else if (flush || (ms_to_ws_valid && ws_allowin)) buf_valid <= 1'b0;
    else if (buf_write)                          buf_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (buf_write) buf_data <= data_rdata;
  end

  // A data_ok taken by MEM in the flush cycle is no longer outstanding, so it
  // must not be counted as a response to swallow.
  always_comb begin
    cnt_next = {1'b0, cancel_cnt};
    if (flush)
      cnt_next = cnt_next + (CNT_W+1)'(wait_data & ~owned_ok) + (CNT_W+1)'(es_req_pending);
    if (discard_ok)
      cnt_next = cnt_next - (CNT_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cancel_cnt <= '0;
    else       cancel_cnt <= cnt_next[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (cnt_next <= (CNT_W+1)'(MAX_OUTST));
  end

  assign load_data = buf_valid ? buf_data : data_rdata;

  load_align #(.LWLR_EN(LWLR_EN)) u_align (
    .load_type (entry.load_type),
    .addr_low  (entry.vaddr[1:0]),
    .rdata     (load_data[31:0]),
    .rt        (entry.rt_value),
    .result    (aligned)
  );

  assign final_result = entry.res_from_mem ? aligned : entry.alu_result;

  always_comb begin
    ms_exc_type = entry.exc_type;
    if (entry.exc_type == 4'h0)
      ms_exc_type = misaligned(entry.load_type, entry.vaddr[1:0]) ? ADEL_MEM : 4'h0;
  end

  assign ms_eret      = entry.eret & ms_valid;
  assign out_ms_valid = ms_valid;

  always_comb begin
    out_bus.vaddr        = entry.vaddr;
    out_bus.bd           = entry.bd;
    out_bus.eret         = entry.eret;
    out_bus.exc_type     = ms_exc_type;
    out_bus.rd_sel       = entry.rd_sel;
    out_bus.res_from_cp0 = entry.res_from_cp0;
    out_bus.mtc0_we      = entry.mtc0_we;
    out_bus.gr_we        = entry.gr_we;
    out_bus.dest         = entry.dest;
    out_bus.result       = final_result;
    out_bus.pc           = entry.pc;
  end

  assign ms_to_ws_bus = out_bus;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs: alignment, hold buffer,
// zero-latency pass, cancel counting and misalignment exceptions.
module tb_mem_stage_hs;
  import mem_stage_hs_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic                       data_ok;
  logic [31:0]                data_rdata;
  logic                       es_req_pending;
  logic                       ws_ex;
  logic                       eret_flush;
  logic                       out_ms_valid;
  logic [3:0]                 ms_exc_type;
  logic                       ms_eret;
  ms_to_ws_t                  out_bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign out_bus = ms_to_ws_t'(ms_to_ws_bus);

  mem_stage_hs dut (
    .clk            (clk),
    .reset          (reset),
    .ws_allowin     (ws_allowin),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .data_ok        (data_ok),
    .data_rdata     (data_rdata),
    .es_req_pending (es_req_pending),
    .ws_ex          (ws_ex),
    .eret_flush     (eret_flush),
    .out_ms_valid   (out_ms_valid),
    .ms_exc_type    (ms_exc_type),
    .ms_eret        (ms_eret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  function automatic es_to_ms_t mk(input load_type_t t, input logic [31:0] va, input logic rs,
                                   input logic [3:0] exc, input logic [31:0] rt,
                                   input logic [31:0] alu);
    es_to_ms_t m;
    m              = '0;
    m.load_type    = t;
    m.res_from_mem = (t != LT_NONE);
    m.req_sent     = rs;
    m.vaddr        = va;
    m.exc_type     = exc;
    m.rt_value     = rt;
    m.alu_result   = alu;
    m.gr_we        = 1'b1;
    m.dest         = 5'd8;
    m.pc           = 32'hbfc0_0000 | {16'h0, va[15:0]};
    return m;
  endfunction

  task automatic send(input es_to_ms_t e);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = e;
    next_cycle();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic load_exec(input string tag, input load_type_t t, input logic [31:0] va,
                           input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] exp);
    send(mk(t, va, 1'b1, 4'h0, rt, 32'h0));
    data_ok    = 1'b1;
    data_rdata = rd;
    settle();
    chk({tag, "_valid"}, ms_to_ws_valid, 1);
    chk(tag, out_bus.result, exp);
    next_cycle();
    data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_ok = 1'b0; data_rdata = '0; es_req_pending = 1'b0; ws_ex = 1'b0; eret_flush = 1'b0;
    next_cycle();
    next_cycle();
    settle();
    chk("rst_valid", ms_to_ws_valid, 0);
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_ms_valid", out_ms_valid, 0);
    chk("rst_eret", ms_eret, 0);
    next_cycle();
    reset = 1'b0;
    settle();
    chk("rst_cancel", dut.cancel_cnt, 0);
    chk("rst_buf", dut.buf_valid, 0);
    next_cycle();

    // LW waits for data, then passes in the data_ok cycle
    send(mk(LT_LW, 32'h0000_1000, 1'b1, 4'h0, 32'h0, 32'h0));
    settle();
    chk("lw_wait_valid", ms_to_ws_valid, 0);
    chk("lw_wait_allowin", ms_allowin, 0);
    next_cycle();
    data_ok = 1'b1; data_rdata = 32'h1234_5678;
    settle();
    chk("lw_zl_valid", ms_to_ws_valid, 1);
    chk("lw_zl_result", out_bus.result, 32'h1234_5678);
    chk("lw_zl_allowin", ms_allowin, 1);
    next_cycle();
    data_ok = 1'b0;
    settle();
    chk("lw_zl_nobuf", dut.buf_valid, 0);
    chk("lw_zl_left", out_ms_valid, 0);
    next_cycle();

    load_exec("lb3",  LT_LB,  32'h0000_2003, 32'h0, 32'h80AA_BBCC, 32'hFFFF_FF80);
    load_exec("lbu3", LT_LBU, 32'h0000_2003, 32'h0, 32'h80AA_BBCC, 32'h0000_0080);
    load_exec("lhu2", LT_LHU, 32'h0000_2002, 32'h0, 32'h80AA_BBCC, 32'h0000_80AA);
    load_exec("lh0",  LT_LH,  32'h0000_2000, 32'h0, 32'h80AA_BBCC, 32'hFFFF_BBCC);
    load_exec("lwr1", LT_LWR, 32'h0000_2001, 32'h1122_3344, 32'hAABB_CCDD, 32'h11AA_BBCC);
    load_exec("lwl0", LT_LWL, 32'h0000_2000, 32'h1122_3344, 32'hAABB_CCDD, 32'hDD22_3344);
    load_exec("lwl2", LT_LWL, 32'h0000_2002, 32'h1122_3344, 32'hAABB_CCDD, 32'hBBCC_DD44);

    // WB stalls: data is held in the buffer and survives later bus activity
    send(mk(LT_LW, 32'h0000_2004, 1'b1, 4'h0, 32'h0, 32'h0));
    ws_allowin = 1'b0; data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    settle();
    chk("hold_ready", ms_to_ws_valid, 1);
    chk("hold_allowin", ms_allowin, 0);
    next_cycle();
    data_ok = 1'b0; data_rdata = 32'hDEAD_BEEF;
    settle();
    chk("hold_buf", dut.buf_valid, 1);
    chk("hold_keep", out_bus.result, 32'hCAFE_F00D);
    next_cycle();
    data_ok = 1'b1; data_rdata = 32'h5555_5555;
    settle();
    chk("hold_ignore", out_bus.result, 32'hCAFE_F00D);
    next_cycle();
    data_ok = 1'b0;
    settle();
    chk("hold_ignore_cnt", dut.cancel_cnt, 0);
    next_cycle();
    ws_allowin = 1'b1;
    settle();
    chk("hold_issue_valid", ms_to_ws_valid, 1);
    chk("hold_issue_result", out_bus.result, 32'hCAFE_F00D);
    next_cycle();
    settle();
    chk("hold_clear_buf", dut.buf_valid, 0);
    chk("hold_left", out_ms_valid, 0);
    next_cycle();

    // Flush while waiting with another request pending: two responses swallowed
    send(mk(LT_LW, 32'h0000_3004, 1'b1, 4'h0, 32'h0, 32'h0));
    ws_ex = 1'b1; es_req_pending = 1'b1;
    next_cycle();
    ws_ex = 1'b0; es_req_pending = 1'b0;
    settle();
    chk("flush_cnt", dut.cancel_cnt, 2);
    chk("flush_valid", out_ms_valid, 0);
    next_cycle();
    send(mk(LT_LW, 32'h0000_3008, 1'b1, 4'h0, 32'h0, 32'h0));
    data_ok = 1'b1; data_rdata = 32'h1111_1111;
    settle();
    chk("cancel1_valid", ms_to_ws_valid, 0);
    next_cycle();
    data_rdata = 32'h2222_2222;
    settle();
    chk("cancel2_valid", ms_to_ws_valid, 0);
    chk("cancel2_cnt", dut.cancel_cnt, 1);
    next_cycle();
    data_rdata = 32'h3333_3333;
    settle();
    chk("cancel3_cnt", dut.cancel_cnt, 0);
    chk("cancel3_valid", ms_to_ws_valid, 1);
    chk("cancel3_result", out_bus.result, 32'h3333_3333);
    next_cycle();
    data_ok = 1'b0;

    // ERET flush in the same cycle as the owned response: only the pending one counts
    send(mk(LT_LW, 32'h0000_300C, 1'b1, 4'h0, 32'h0, 32'h0));
    data_ok = 1'b1; data_rdata = 32'h4444_4444; eret_flush = 1'b1; es_req_pending = 1'b1;
    next_cycle();
    eret_flush = 1'b0; es_req_pending = 1'b0; data_ok = 1'b0;
    settle();
    chk("eflush_cnt", dut.cancel_cnt, 1);
    chk("eflush_valid", out_ms_valid, 0);
    next_cycle();
    data_ok = 1'b1;
    next_cycle();
    data_ok = 1'b0;
    settle();
    chk("eflush_drain", dut.cancel_cnt, 0);
    next_cycle();

    // Misaligned LH raises ADEL and never waits; existing exception passes through
    send(mk(LT_LH, 32'h0000_4001, 1'b0, 4'h0, 32'h0, 32'h0));
    settle();
    chk("adel_exc", ms_exc_type, ADEL_MEM);
    chk("adel_bus_exc", out_bus.exc_type, ADEL_MEM);
    chk("adel_ready", ms_to_ws_valid, 1);
    next_cycle();
    send(mk(LT_LW, 32'h0000_4002, 1'b0, 4'h1, 32'h0, 32'h0));
    settle();
    chk("preexc_pass", ms_exc_type, 4'h1);
    next_cycle();
    begin
      es_to_ms_t e;
      e = mk(LT_NONE, 32'h0000_5000, 1'b0, 4'h0, 32'h0, 32'h0BAD_F00D);
      e.eret = 1'b1;
      send(e);
    end
    settle();
    chk("alu_valid", ms_to_ws_valid, 1);
    chk("alu_result", out_bus.result, 32'h0BAD_F00D);
    chk("alu_eret", ms_eret, 1);
    chk("alu_noexc", ms_exc_type, 4'h0);
    next_cycle();
    settle();
    chk("final_empty", out_ms_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
